// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared FSM state type and parameter derivation helpers
// for the sliding-window line-buffer controller.
package line_buf_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        FILL,
        FILL_GAP,
        RUN,
        RUN_GAP,
        POST,
        POST_GAP
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int half_of(input int k);
        return (k - 1) / 2;
    endfunction

    function automatic int nbuf_of(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/line_buf_pad_gen.sv
// line_buf_pad_gen: flags window rows above the image top or below the
// last counted row; the mask is captured at the start of each output row.
module line_buf_pad_gen
    import line_buf_pkg::*;
#(
    parameter int KSIZE = 5,
    parameter int RW    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic [RW:0]       r,
    input  logic [RW-1:0]     rows,
    output logic [KSIZE-1:0]  pad_mask
);

    localparam int HALF = half_of(KSIZE);

    logic [KSIZE-1:0] mask_c;
    logic [RW+1:0]    row_i;

    // row_i is two's complement; its MSB marks rows above the image
    always_comb begin
        mask_c = '0;
        row_i  = '0;
        for (int i = 0; i < KSIZE; i++) begin
            row_i = {r[RW], r} + (RW+2)'(i) - (RW+2)'(HALF);
            mask_c[i] = row_i[RW+1] |
                        (row_i[RW:0] >= {1'b0, rows});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_mask <= '0;
        end else if (clr) begin
            pad_mask <= '0;
        end else if (load) begin
            pad_mask <= mask_c;
        end
    end

endmodule

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: rotates write enables over KSIZE+1 line memories, issues
// aligned reads, generates trailing rows and checks frame geometry.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int IMG_COL = 1920,
    parameter int IMG_ROW = 1080,
    parameter int KSIZE   = 5,
    parameter int HBLANK  = 280,
    parameter int AW      = 11,
    parameter int RW      = 12,
    localparam int NBUF   = nbuf_of(KSIZE),
    localparam int IW     = clog2(NBUF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              vref,
    input  logic              href,
    input  logic              de,
    output logic [NBUF-1:0]   wr_en,
    output logic [NBUF-1:0]   rd_en,
    output logic [AW-1:0]     mem_addr,
    output logic [IW-1:0]     win_base,
    output logic              out_de,
    output logic [RW-1:0]     out_row,
    output logic [KSIZE-1:0]  pad_mask,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int HALF = half_of(KSIZE);
    localparam int CW   = AW + 1;
    localparam int GW   = clog2(HBLANK + 1);

    state_t          state_q, state_d;
    logic            vref_q, href_q;
    logic [CW-1:0]   col_q, col_d, col_in;
    logic [GW-1:0]   gap_q, gap_d;
    logic [RW-1:0]   cur_k_q, cur_k_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d, wr_inc;
    logic [AW-1:0]   addr_c;
    logic [RW:0]     r_d;
    logic            pix_wr, pix_rd, first_c, err_c, done_c;
    logic            next_row, post_start, next_post, abort;
    logic            vref_rise, vref_fall, href_rise;

    assign vref_rise = vref & ~vref_q;
    assign vref_fall = ~vref & vref_q;
    assign href_rise = href & ~href_q;
    assign wr_inc    = (wr_idx_q == IW'(NBUF-1)) ? '0 : wr_idx_q + 1'b1;
    assign r_d       = {1'b0, cur_k_d} - (RW+1)'(HALF + 1);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        gap_d      = gap_q;
        cur_k_d    = cur_k_q;
        row_cnt_d  = row_cnt_q;
        wr_idx_d   = wr_idx_q;
        col_in     = '0;
        addr_c     = mem_addr;
        pix_wr     = 1'b0;
        pix_rd     = 1'b0;
        first_c    = 1'b0;
        err_c      = 1'b0;
        done_c     = 1'b0;
        next_row   = 1'b0;
        post_start = 1'b0;
        next_post  = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            IDLE: begin
                col_d     = '0;
                gap_d     = '0;
                cur_k_d   = '0;
                row_cnt_d = '0;
                wr_idx_d  = '0;
                if (vref_rise) state_d = WAIT_ROW;
            end
            WAIT_ROW: begin
                if (vref_fall) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else if (href_rise) begin
                    state_d   = FILL;
                    cur_k_d   = '0;
                    row_cnt_d = RW'(1);
                    wr_idx_d  = '0;
                    col_d     = '0;
                end
            end
            FILL: begin
                if (vref_fall) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else if (!href) begin
                    state_d = FILL_GAP;
                end
            end
            FILL_GAP: begin
                if (vref_fall) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else if (href_rise) begin
                    next_row = 1'b1;
                    state_d  = (row_cnt_q == RW'(HALF + 1)) ? RUN : FILL;
                end
            end
            RUN: begin
                if (vref_fall) post_start = 1'b1;
                else if (!href) state_d = RUN_GAP;
            end
            RUN_GAP: begin
                if (vref_fall) post_start = 1'b1;
                else if (href_rise) begin
                    next_row = 1'b1;
                    state_d  = RUN;
                end
            end
            POST: begin
                if (vref_rise) begin
                    abort = 1'b1;
                end else begin
                    pix_rd  = 1'b1;
                    addr_c  = col_q[AW-1:0];
                    first_c = (col_q == '0);
                    col_d   = col_q + 1'b1;
                    if (col_q == CW'(IMG_COL - 1)) begin
                        state_d = POST_GAP;
                        gap_d   = '0;
                    end
                end
            end
            POST_GAP: begin
                if (vref_rise) begin
                    abort = 1'b1;
                end else if (gap_q == GW'(HBLANK - 1)) begin
                    if (cur_k_q == row_cnt_q + RW'(HALF)) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        next_post = 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (next_row) begin
            cur_k_d   = row_cnt_q;
            row_cnt_d = row_cnt_q + 1'b1;
            wr_idx_d  = wr_inc;
            col_d     = '0;
        end
        // the row-count check happens once, when the input frame ends
        if (post_start) begin
            err_c     = (row_cnt_q != RW'(IMG_ROW));
            next_post = 1'b1;
        end
        if (next_post) begin
            state_d  = POST;
            cur_k_d  = cur_k_q + 1'b1;
            wr_idx_d = wr_inc;
            col_d    = '0;
        end
        if (abort) begin
            err_c     = 1'b1;
            state_d   = WAIT_ROW;
            col_d     = '0;
            gap_d     = '0;
            cur_k_d   = '0;
            row_cnt_d = '0;
            wr_idx_d  = '0;
        end

        if (href && de && (state_d == FILL || state_d == RUN)) begin
            col_in = href_rise ? '0 : col_q;
            if (col_in < CW'(IMG_COL)) begin
                pix_wr  = 1'b1;
                pix_rd  = (state_d == RUN);
                addr_c  = col_in[AW-1:0];
                first_c = (col_in == '0);
                col_d   = col_in + 1'b1;
            end else begin
                addr_c = AW'(IMG_COL - 1);
                if (col_in == CW'(IMG_COL)) begin
                    err_c = 1'b1;
                    col_d = col_in + 1'b1;
                end
            end
        end

        if (!en) begin
            state_d   = IDLE;
            col_d     = '0;
            gap_d     = '0;
            cur_k_d   = '0;
            row_cnt_d = '0;
            wr_idx_d  = '0;
            addr_c    = '0;
            pix_wr    = 1'b0;
            pix_rd    = 1'b0;
            err_c     = 1'b0;
            done_c    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vref_q     <= 1'b0;
            href_q     <= 1'b0;
            col_q      <= '0;
            gap_q      <= '0;
            cur_k_q    <= '0;
            row_cnt_q  <= '0;
            wr_idx_q   <= '0;
            wr_en      <= '0;
            rd_en      <= '0;
            mem_addr   <= '0;
            win_base   <= '0;
            out_de     <= 1'b0;
            out_row    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vref_q     <= vref;
            href_q     <= href;
            col_q      <= col_d;
            gap_q      <= gap_d;
            cur_k_q    <= cur_k_d;
            row_cnt_q  <= row_cnt_d;
            wr_idx_q   <= wr_idx_d;
            wr_en      <= pix_wr ? (NBUF'(1) << wr_idx_d) : '0;
            rd_en      <= pix_rd ? ~(NBUF'(1) << wr_idx_d) : '0;
            mem_addr   <= addr_c;
            out_de     <= pix_rd;
            busy       <= en && (state_d != IDLE);
            frame_done <= done_c;
            frame_err  <= err_c;
            if (!en) begin
                out_row  <= '0;
                win_base <= '0;
            end else if (pix_rd && first_c) begin
                out_row  <= r_d[RW-1:0];
                win_base <= (wr_idx_d == IW'(NBUF-1)) ? '0 : wr_idx_d + 1'b1;
            end
        end
    end

    line_buf_pad_gen #(
        .KSIZE (KSIZE),
        .RW    (RW)
    ) u_pad (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (!en),
        .load     (pix_rd && first_c),
        .r        (r_d),
        .rows     (row_cnt_d),
        .pad_mask (pad_mask)
    );

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: directed scenarios for the line-buffer controller with
// KSIZE=3, IMG_COL=8, IMG_ROW=6, HBLANK=4.
module tb_line_buf_ctrl;

    localparam int IMG_COL = 8;
    localparam int IMG_ROW = 6;
    localparam int KSIZE   = 3;
    localparam int HBLANK  = 4;
    localparam int AW      = 11;
    localparam int RW      = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic vref = 1'b0;
    logic href = 1'b0;
    logic de = 1'b0;
    logic [3:0]      wr_en, rd_en;
    logic [AW-1:0]   mem_addr;
    logic [1:0]      win_base;
    logic            out_de, busy, frame_done, frame_err;
    logic [RW-1:0]   out_row;
    logic [2:0]      pad_mask;

    int checks = 0;
    int failures = 0;

    line_buf_ctrl #(
        .IMG_COL (IMG_COL),
        .IMG_ROW (IMG_ROW),
        .KSIZE   (KSIZE),
        .HBLANK  (HBLANK),
        .AW      (AW),
        .RW      (RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .vref       (vref),
        .href       (href),
        .de         (de),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .mem_addr   (mem_addr),
        .win_base   (win_base),
        .out_de     (out_de),
        .out_row    (out_row),
        .pad_mask   (pad_mask),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // event monitor, sampled on the falling edge
    logic          mon_clr = 1'b0;
    int            n_err = 0, n_done = 0, n_ode = 0, n_wr = 0, cyc = 0;
    logic [RW-1:0] q_row[$];
    logic [2:0]    q_pad[$];
    logic [1:0]    q_wb[$];
    int            q_t[$];
    logic [3:0]    q_wr[$];
    logic          ode_q = 1'b0;
    logic [3:0]    wr_q = 4'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_clr) begin
            n_err = 0; n_done = 0; n_ode = 0; n_wr = 0;
            q_row.delete(); q_pad.delete(); q_wb.delete();
            q_t.delete(); q_wr.delete();
        end else begin
            if (frame_err) n_err = n_err + 1;
            if (frame_done) n_done = n_done + 1;
            if (out_de) n_ode = n_ode + 1;
            if (wr_en != 4'b0) n_wr = n_wr + 1;
            if (out_de && !ode_q) begin
                q_row.push_back(out_row);
                q_pad.push_back(pad_mask);
                q_wb.push_back(win_base);
                q_t.push_back(cyc);
            end
            if (wr_en != 4'b0 && wr_q == 4'b0) q_wr.push_back(wr_en);
        end
        ode_q = out_de;
        wr_q  = wr_en;
    end

    logic [AW-1:0] row_addr, ovf_addr;
    logic [3:0]    row_wr, ovf_wr;
    bit            to;
    logic [3:0]    exp_wr [6] = '{4'b0001, 4'b0010, 4'b0100,
                                  4'b1000, 4'b0001, 4'b0010};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon;
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic send_row(input int nde);
        href = 1'b1;
        tick();
        repeat (nde) begin
            de = 1'b1;
            tick();
        end
        row_addr = mem_addr;
        row_wr   = wr_en;
        de   = 1'b0;
        href = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input int nrows, input int big_row);
        vref = 1'b1;
        tick();
        for (int r = 0; r < nrows; r++) begin
            send_row((r == big_row) ? IMG_COL + 2 : IMG_COL);
            if (r == big_row) begin
                ovf_addr = row_addr;
                ovf_wr   = row_wr;
            end
        end
    endtask

    task automatic end_frame(output bit t_o);
        vref = 1'b0;
        t_o  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!busy) begin
                t_o = 1'b0;
                break;
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) tick();
        checks++; if (wr_en !== 4'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0000", wr_en); end
        checks++; if (rd_en !== 4'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0000", rd_en); end
        checks++; if ({out_de, busy, frame_done, frame_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {out_de, busy, frame_done, frame_err}); end
        checks++; if ({mem_addr, out_row, pad_mask, win_base} !== '0) begin failures++; $display("FAIL reset_regs addr=%0d row=%0d pad=%b wb=%0d want=0", mem_addr, out_row, pad_mask, win_base); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_nominal;
        clr_mon();
        vref = 1'b1;
        tick();
        send_row(IMG_COL);
        send_row(IMG_COL);
        checks++; if (n_ode !== 0) begin failures++; $display("FAIL nom_fill_no_out got=%0d want=0", n_ode); end
        for (int r = 2; r < 6; r++) send_row(IMG_COL);
        end_frame(to);
        checks++; if (to) begin failures++; $display("FAIL nom_timeout got=busy want=idle"); end
        checks++; if (q_wr.size() != 6) begin failures++; $display("FAIL nom_wr_rows got=%0d want=6", q_wr.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (q_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL nom_wr_en[%0d] got=%b want=%b", i, q_wr[i], exp_wr[i]); end
        end
        checks++; if ({q_row[0], q_pad[0], q_wb[0]} !== {12'd0, 3'b001, 2'd3}) begin failures++; $display("FAIL nom_first_out row=%0d pad=%b wb=%0d want 0/001/3", q_row[0], q_pad[0], q_wb[0]); end
        checks++; if ({q_row[4], q_pad[4]} !== {12'd4, 3'b000}) begin failures++; $display("FAIL nom_post0 row=%0d pad=%b want 4/000", q_row[4], q_pad[4]); end
        checks++; if ({q_row[5], q_pad[5], q_wb[5]} !== {12'd5, 3'b100, 2'd0}) begin failures++; $display("FAIL nom_post1 row=%0d pad=%b wb=%0d want 5/100/0", q_row[5], q_pad[5], q_wb[5]); end
        checks++; if (q_t[5] - q_t[4] != IMG_COL + HBLANK) begin failures++; $display("FAIL nom_post_gap got=%0d want=%0d", q_t[5] - q_t[4], IMG_COL + HBLANK); end
        checks++; if (n_ode !== 48) begin failures++; $display("FAIL nom_out_de_cnt got=%0d want=48", n_ode); end
        checks++; if (n_wr !== 48) begin failures++; $display("FAIL nom_wr_cnt got=%0d want=48", n_wr); end
        checks++; if ({n_done, n_err} !== {32'd1, 32'd0}) begin failures++; $display("FAIL nom_done_err done=%0d err=%0d want 1/0", n_done, n_err); end
    endtask

    task automatic test_short_frame;
        clr_mon();
        send_frame(4, -1);
        end_frame(to);
        checks++; if (to) begin failures++; $display("FAIL short_timeout got=busy want=idle"); end
        checks++; if (n_err !== 1) begin failures++; $display("FAIL short_err got=%0d want=1", n_err); end
        checks++; if (q_row.size() != 4) begin failures++; $display("FAIL short_rows got=%0d want=4", q_row.size()); end
        checks++; if ({q_row[2], q_pad[2]} !== {12'd2, 3'b000}) begin failures++; $display("FAIL short_post0 row=%0d pad=%b want 2/000", q_row[2], q_pad[2]); end
        checks++; if ({q_row[3], q_pad[3]} !== {12'd3, 3'b100}) begin failures++; $display("FAIL short_post1 row=%0d pad=%b want 3/100", q_row[3], q_pad[3]); end
        checks++; if (n_done !== 1) begin failures++; $display("FAIL short_done got=%0d want=1", n_done); end
    endtask

    task automatic test_col_overflow;
        clr_mon();
        send_frame(6, 1);
        end_frame(to);
        checks++; if (to) begin failures++; $display("FAIL ovf_timeout got=busy want=idle"); end
        checks++; if (ovf_addr !== AW'(7)) begin failures++; $display("FAIL ovf_addr got=%0d want=7", ovf_addr); end
        checks++; if (ovf_wr !== 4'b0) begin failures++; $display("FAIL ovf_wr_en got=%b want=0000", ovf_wr); end
        checks++; if (n_wr !== 48) begin failures++; $display("FAIL ovf_wr_cnt got=%0d want=48", n_wr); end
        checks++; if (n_err !== 1) begin failures++; $display("FAIL ovf_err got=%0d want=1", n_err); end
    endtask

    task automatic test_en_drop;
        clr_mon();
        vref = 1'b1;
        tick();
        for (int r = 0; r < 3; r++) send_row(IMG_COL);
        href = 1'b1;
        tick();
        repeat (5) begin
            de = 1'b1;
            tick();
        end
        checks++; if ({out_de, out_row} !== {1'b1, 12'd1}) begin failures++; $display("FAIL endrop_pre de=%b row=%0d want 1/1", out_de, out_row); end
        en = 1'b0;
        tick();
        checks++; if ({wr_en, rd_en} !== 8'b0) begin failures++; $display("FAIL endrop_en got=%b/%b want=0", wr_en, rd_en); end
        checks++; if ({out_de, busy, frame_done, frame_err} !== 4'b0) begin failures++; $display("FAIL endrop_flags got=%b want=0000", {out_de, busy, frame_done, frame_err}); end
        checks++; if ({mem_addr, out_row, pad_mask, win_base} !== '0) begin failures++; $display("FAIL endrop_regs addr=%0d row=%0d pad=%b wb=%0d want=0", mem_addr, out_row, pad_mask, win_base); end
        de = 1'b0; href = 1'b0; vref = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        tick();
        clr_mon();
        send_frame(6, -1);
        end_frame(to);
        checks++; if (to) begin failures++; $display("FAIL reen_timeout got=busy want=idle"); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (q_wr[i] !== exp_wr[i]) begin failures++; $display("FAIL reen_wr_en[%0d] got=%b want=%b", i, q_wr[i], exp_wr[i]); end
        end
        checks++; if ({q_row[0], q_pad[0], q_wb[0]} !== {12'd0, 3'b001, 2'd3}) begin failures++; $display("FAIL reen_first_out row=%0d pad=%b wb=%0d want 0/001/3", q_row[0], q_pad[0], q_wb[0]); end
        checks++; if ({q_row[5], q_pad[5]} !== {12'd5, 3'b100}) begin failures++; $display("FAIL reen_post1 row=%0d pad=%b want 5/100", q_row[5], q_pad[5]); end
        checks++; if ({n_ode, n_err, n_done} !== {32'd48, 32'd0, 32'd1}) begin failures++; $display("FAIL reen_counts ode=%0d err=%0d done=%0d want 48/0/1", n_ode, n_err, n_done); end
    endtask

    task automatic test_vref_in_post;
        clr_mon();
        send_frame(6, -1);
        vref = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (q_row.size() >= 5 && !out_de) begin
                to = 1'b0;
                break;
            end
        end
        checks++; if (to) begin failures++; $display("FAIL vpost_wait got=no_gap want=post_gap"); end
        vref = 1'b1;
        tick();
        checks++; if ({frame_err, busy} !== 2'b11) begin failures++; $display("FAIL vpost_abort err=%b busy=%b want 1/1", frame_err, busy); end
        repeat (20) tick();
        checks++; if (q_row.size() != 5 || n_ode !== 40) begin failures++; $display("FAIL vpost_dropped rows=%0d ode=%0d want 5/40", q_row.size(), n_ode); end
        checks++; if ({n_err, n_done} !== {32'd1, 32'd0}) begin failures++; $display("FAIL vpost_pulses err=%0d done=%0d want 1/0", n_err, n_done); end
        clr_mon();
        send_frame(6, -1);
        end_frame(to);
        checks++; if (to) begin failures++; $display("FAIL vpost_next_timeout got=busy want=idle"); end
        checks++; if (q_wr[0] !== 4'b0001) begin failures++; $display("FAIL vpost_next_wr got=%b want=0001", q_wr[0]); end
        checks++; if ({n_err, n_done} !== {32'd0, 32'd1}) begin failures++; $display("FAIL vpost_next_pulses err=%0d done=%0d want 0/1", n_err, n_done); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_frame();
        test_col_overflow();
        test_en_drop();
        test_vref_in_post();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
